// File: rtl/soc_spi_pkg.sv
// Shared types and constants for the SPI slave register bank.
package soc_spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } spi_state_e;

    localparam int unsigned CMD_RW_BIT      = 7;
    localparam int unsigned SPI_BYTE_BITS   = 8;
    localparam int unsigned BIT_CNT_W       = $clog2(SPI_BYTE_BITS);
    localparam logic [7:0]  DEFAULT_ID_BYTE = 8'hA5;

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizer for one SPI pin with rise/fall pulses on the synced level.
module spi_pin_sync (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic dly_q,  dly_d;

    always_comb begin
        meta_d = pin;
        sync_d = meta_q;
        dly_d  = sync_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            dly_q  <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            dly_q  <= dly_d;
        end
    end

    assign sync = sync_q;
    assign rise = sync_q & ~dly_q;
    assign fall = ~sync_q & dly_q;

endmodule

// File: rtl/spi_slave_regbank.sv
// SPI mode-0 slave exposing NREGS 8-bit registers; command byte then auto-increment data bytes.
module spi_slave_regbank
    import soc_spi_pkg::*;
#(
    parameter int unsigned NREGS   = 16,
    parameter logic [7:0]  ID_BYTE = DEFAULT_ID_BYTE,
    localparam int unsigned AW     = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          spi_sck,
    input  logic          spi_mosi,
    input  logic          spi_cs,
    output logic          spi_miso,
    output logic          spi_miso_oe,
    input  logic [AW-1:0] loc_addr,
    output logic [7:0]    loc_rdata,
    output logic          wr_pulse,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic          busy
);

    logic sck_rise, sck_fall, sck_level_unused;
    logic cs_rise, cs_fall, cs_level_unused;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_pin_sync u_sync_sck (
        .clk  (clk),
        .rst  (reset),
        .pin  (spi_sck),
        .sync (sck_level_unused),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    spi_pin_sync u_sync_cs (
        .clk  (clk),
        .rst  (reset),
        .pin  (spi_cs),
        .sync (cs_level_unused),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    spi_pin_sync u_sync_mosi (
        .clk  (clk),
        .rst  (reset),
        .pin  (spi_mosi),
        .sync (mosi_s),
        .rise (mosi_rise_unused),
        .fall (mosi_fall_unused)
    );

    spi_state_e           state_q, state_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [6:0]           rx_q, rx_d;
    logic [7:0]           tx_q, tx_d;
    logic                 rw_q, rw_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic                 miso_q, miso_d;
    logic                 oe_q, oe_d;
    logic                 wr_pulse_q, wr_pulse_d;
    logic [AW-1:0]        wr_addr_q, wr_addr_d;
    logic [7:0]           wr_data_q, wr_data_d;
    logic [7:0]           regs_q [NREGS];
    logic [7:0]           regs_d [NREGS];

    logic [7:0]    rx_byte;
    logic [AW-1:0] addr_next;
    logic          last_bit;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_d       = rx_q;
        tx_d       = tx_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        miso_d     = miso_q;
        oe_d       = oe_q;
        wr_pulse_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        regs_d     = regs_q;
        rx_byte    = {rx_q, mosi_s};
        addr_next  = addr_q + AW'(1);
        last_bit   = (bit_cnt_q == BIT_CNT_W'(SPI_BYTE_BITS - 1));

        if (cs_rise) begin
            state_d   = ST_IDLE;
            oe_d      = 1'b0;
            miso_d    = 1'b0;
            bit_cnt_d = '0;
            rx_d      = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cs_fall) begin
                        tx_d      = ID_BYTE;
                        miso_d    = ID_BYTE[7];
                        oe_d      = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (sck_rise) begin
                        rx_d      = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                        if (last_bit) begin
                            rw_d    = rx_byte[CMD_RW_BIT];
                            addr_d  = rx_byte[AW-1:0];
                            state_d = ST_DATA;
                            if (rx_byte[CMD_RW_BIT]) begin
                                tx_d = regs_q[rx_byte[AW-1:0]];
                            end
                        end
                    end else if (sck_fall) begin
                        // First fall of a byte presents the freshly loaded MSB without shifting.
                        if (bit_cnt_q == '0) begin
                            miso_d = tx_q[7];
                        end else begin
                            miso_d = tx_q[6];
                            tx_d   = {tx_q[6:0], 1'b0};
                        end
                    end
                end
                ST_DATA: begin
                    if (sck_rise) begin
                        rx_d      = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                        if (last_bit) begin
                            addr_d = addr_next;
                            if (rw_q) begin
                                tx_d = regs_q[addr_next];
                            end else begin
                                regs_d[addr_q] = rx_byte;
                                wr_pulse_d     = 1'b1;
                                wr_addr_d      = addr_q;
                                wr_data_d      = rx_byte;
                            end
                        end
                    end else if (sck_fall) begin
                        if (!rw_q) begin
                            miso_d = 1'b0;
                        end else if (bit_cnt_q == '0) begin
                            miso_d = tx_q[7];
                        end else begin
                            miso_d = tx_q[6];
                            tx_d   = {tx_q[6:0], 1'b0};
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            rx_q       <= '0;
            tx_q       <= '0;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            miso_q     <= 1'b0;
            oe_q       <= 1'b0;
            wr_pulse_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_q       <= rx_d;
            tx_q       <= tx_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            miso_q     <= miso_d;
            oe_q       <= oe_d;
            wr_pulse_q <= wr_pulse_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            regs_q     <= regs_d;
        end
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = oe_q;
    assign loc_rdata   = regs_q[loc_addr];
    assign wr_pulse    = wr_pulse_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_slave_regbank.sv
// Directed bench: acts as SPI master (sck = clk/10) and checks MISO, strobes and local reads.
module tb_spi_slave_regbank;

    logic       clk = 1'b0;
    logic       reset;
    logic       spi_sck, spi_mosi, spi_cs;
    logic       spi_miso, spi_miso_oe;
    logic [3:0] loc_addr;
    logic [7:0] loc_rdata;
    logic       wr_pulse;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [3:0] pa [$];
    logic [7:0] pd [$];
    logic [7:0] rx;

    spi_slave_regbank #(.NREGS(16), .ID_BYTE(8'hA5)) dut (
        .clk         (clk),
        .reset       (reset),
        .spi_sck     (spi_sck),
        .spi_mosi    (spi_mosi),
        .spi_cs      (spi_cs),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .loc_addr    (loc_addr),
        .loc_rdata   (loc_rdata),
        .wr_pulse    (wr_pulse),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_pulse === 1'b1) begin
            pa.push_back(wr_addr);
            pd.push_back(wr_data);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic [7:0] tx, input int unsigned nbits, output logic [7:0] rxb);
        rxb = '0;
        for (int unsigned i = 0; i < nbits; i++) begin
            spi_mosi = tx[7-i];
            #50;
            spi_sck = 1'b1;
            rxb[7-i] = spi_miso;
            #50;
            spi_sck = 1'b0;
        end
    endtask

    task automatic cs_low();
        spi_cs = 1'b0;
        #50;
    endtask

    task automatic cs_high();
        #50;
        spi_cs = 1'b1;
        #100;
    endtask

    task automatic write_frame(input logic [7:0] cmd, input logic [7:0] data);
        logic [7:0] r;
        cs_low();
        xfer(cmd, 8, r);
        xfer(data, 8, r);
        cs_high();
    endtask

    task automatic check_pulse(input string tag, input logic [3:0] a, input logic [7:0] d);
        if (pa.size() == 0) begin
            chk({tag, "_present"}, 32'd0, 32'd1);
        end else begin
            chk({tag, "_addr"}, {28'd0, pa.pop_front()}, {28'd0, a});
            chk({tag, "_data"}, {24'd0, pd.pop_front()}, {24'd0, d});
        end
    endtask

    initial begin
        reset    = 1'b1;
        spi_sck  = 1'b0;
        spi_mosi = 1'b0;
        spi_cs   = 1'b1;
        loc_addr = '0;
        #100;
        reset = 1'b0;
        #50;

        // Reset state on an idle bus
        chk("rst_miso", {31'd0, spi_miso}, 32'd0);
        chk("rst_oe", {31'd0, spi_miso_oe}, 32'd0);
        chk("rst_wr_pulse", {31'd0, wr_pulse}, 32'd0);
        chk("rst_wr_addr", {28'd0, wr_addr}, 32'd0);
        chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            loc_addr = 4'(i);
            #1;
            chk($sformatf("rst_reg%0d", i), {24'd0, loc_rdata}, 32'd0);
        end
        #9;

        // Write frame: cmd 0x03, data 0x5A
        cs_low();
        chk("frame_busy", {31'd0, busy}, 32'd1);
        chk("frame_oe", {31'd0, spi_miso_oe}, 32'd1);
        xfer(8'h03, 8, rx);
        chk("cmd_miso_id", {24'd0, rx}, 32'hA5);
        xfer(8'h5A, 8, rx);
        chk("wr_miso_zero", {24'd0, rx}, 32'h00);
        cs_high();
        chk("wr1_count", pa.size(), 32'd1);
        check_pulse("wr1", 4'd3, 8'h5A);
        loc_addr = 4'd3;
        #1;
        chk("loc_reg3", {24'd0, loc_rdata}, 32'h5A);
        #9;
        chk("idle_oe", {31'd0, spi_miso_oe}, 32'd0);

        // Read burst wrapping from 15 to 0
        write_frame(8'h0F, 8'h11);
        write_frame(8'h00, 8'h22);
        pa.delete();
        pd.delete();
        cs_low();
        xfer(8'h8F, 8, rx);
        chk("rd_id", {24'd0, rx}, 32'hA5);
        xfer(8'h00, 8, rx);
        chk("rd_reg15", {24'd0, rx}, 32'h11);
        xfer(8'h00, 8, rx);
        chk("rd_reg0_wrap", {24'd0, rx}, 32'h22);
        cs_high();
        chk("rd_no_pulse", pa.size(), 32'd0);

        // Abort mid-byte: cmd 0x04 then 5 data bits
        cs_low();
        xfer(8'h04, 8, rx);
        xfer(8'hFF, 5, rx);
        #50;
        spi_cs = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_oe", {31'd0, spi_miso_oe}, 32'd0);
        #100;
        chk("abort_no_pulse", pa.size(), 32'd0);
        loc_addr = 4'd4;
        #1;
        chk("abort_reg4", {24'd0, loc_rdata}, 32'h00);
        #9;

        // Reset during a read data byte
        cs_low();
        xfer(8'h8F, 8, rx);
        xfer(8'h00, 3, rx);
        reset = 1'b1;
        #1;
        chk("mid_rst_oe", {31'd0, spi_miso_oe}, 32'd0);
        chk("mid_rst_miso", {31'd0, spi_miso}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        #59;
        reset = 1'b0;
        #50;
        // cs stayed low across reset: traffic must be ignored until a fresh cs fall
        xfer(8'h05, 8, rx);
        xfer(8'h77, 8, rx);
        chk("stale_cs_busy", {31'd0, busy}, 32'd0);
        chk("stale_cs_no_pulse", pa.size(), 32'd0);
        cs_high();
        for (int i = 0; i < 16; i++) begin
            loc_addr = 4'(i);
            #1;
            chk($sformatf("post_rst_reg%0d", i), {24'd0, loc_rdata}, 32'd0);
        end
        #9;
        write_frame(8'h07, 8'h3C);
        chk("post_rst_count", pa.size(), 32'd1);
        check_pulse("post_rst_wr", 4'd7, 8'h3C);
        loc_addr = 4'd7;
        #1;
        chk("post_rst_reg7", {24'd0, loc_rdata}, 32'h3C);
        #9;

        // Write burst of three bytes from address 14, wrapping to 0
        cs_low();
        xfer(8'h0E, 8, rx);
        xfer(8'hA0, 8, rx);
        xfer(8'hA1, 8, rx);
        xfer(8'hA2, 8, rx);
        cs_high();
        chk("burst_count", pa.size(), 32'd3);
        check_pulse("burst0", 4'd14, 8'hA0);
        check_pulse("burst1", 4'd15, 8'hA1);
        check_pulse("burst2", 4'd0, 8'hA2);
        loc_addr = 4'd14;
        #1;
        chk("burst_reg14", {24'd0, loc_rdata}, 32'hA0);
        loc_addr = 4'd15;
        #1;
        chk("burst_reg15", {24'd0, loc_rdata}, 32'hA1);
        loc_addr = 4'd0;
        #1;
        chk("burst_reg0", {24'd0, loc_rdata}, 32'hA2);
        loc_addr = 4'd1;
        #1;
        chk("burst_reg1_untouched", {24'd0, loc_rdata}, 32'h00);
        #20;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spi_slave_regbank.md
Name: spi_slave_regbank

Overview:
- SPI mode-0 slave responder that gives the SoC SPI master a real far end in place of a MISO tied low.
- Holds a bank of NREGS 8-bit registers that the master writes and reads over spi_sck/spi_mosi/spi_cs/spi_miso.
- Oversamples all SPI pins on the system clock. It sits at bench/board level opposite the SoC SPI master.
- Exposes a local inspection port and write-strobe outputs for checking.

Parameters:
- NREGS, 16, number of 8-bit registers (power of two, 2..128); AW = log2(NREGS).
- ID_BYTE, 8'hA5, byte shifted out on MISO during the command byte.

Ports:
- clk  in  1  system clock; must be at least 8x the spi_sck frequency.
- reset  in  1  asynchronous, active-high reset.
- spi_sck  in  1  SPI clock from master, CPOL=0.
- spi_mosi  in  1  master data out.
- spi_cs  in  1  chip select, active-low.
- spi_miso  out  1  slave data out.
- spi_miso_oe  out  1  MISO output enable (1 while selected).
- loc_addr  in  AW  local read address.
- loc_rdata  out  8  combinational read of reg[loc_addr].
- wr_pulse  out  1  one-cycle strobe when an SPI write commits.
- wr_addr  out  AW  address of committed write.
- wr_data  out  8  data of committed write.
- busy  out  1  high while state != IDLE.

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE and all registers clear to 8'h00.
  - spi_miso=0, spi_miso_oe=0, wr_pulse=0, wr_addr=0, wr_data=0, busy=0.
  - Bit counter and shift registers clear to 0.
- Synchronization:
  - spi_sck, spi_mosi and spi_cs each pass through a 2-FF synchronizer.
  - Rise and fall pulses of sck and cs are taken from the synced value and its one-cycle-delayed copy.
  - Pin-to-internal latency is 3 clk.
- Protocol: mode 0, MSB first, 8-bit bytes.
  - Byte 0 is the command: bit7 = 1 for read, 0 for write; bits[AW-1:0] = start address; the remaining bits are ignored.
  - Following bytes are data, with auto-increment of the address.
- States:
  - IDLE: on cs fall, load tx_shift = ID_BYTE, drive spi_miso = ID_BYTE[7], set spi_miso_oe=1, clear bit_cnt, go to CMD.
  - CMD: on sck rise, shift in mosi. On the 8th rise, latch rw and addr, clear bit_cnt, go to DATA. For a read, also load tx_shift = reg[addr] on that same cycle.
  - DATA, write: on the 8th rise, reg[addr] <= byte. The following clk pulses wr_pulse=1 with wr_addr/wr_data. Then addr <= addr+1.
  - DATA, read: on the 8th rise, addr <= addr+1 and tx_shift <= reg[addr+1].
  - MISO in DATA: on each sck fall, spi_miso shifts out the next tx_shift bit.
  - MISO during a write burst is don't-care and is driven to 0.
- Any state: cs rise returns to IDLE, sets spi_miso_oe=0 and spi_miso=0.
  - A partial byte (bit_cnt != 0) is discarded: no write, no wr_pulse.
  - Takes priority over a same-cycle sck edge.
- Address wrap: addr increments modulo NREGS (NREGS-1 -> 0).
- Simultaneous local read and SPI write to the same address: loc_rdata returns the old value that cycle and the new value from the next clk.
- CS low with no sck edges: stays in CMD indefinitely with no side effects.
- Bursts of any length are legal; each complete data byte is one access.
- reset asserted mid-frame: immediate abort per reset values. After reset release with cs already low, the block waits for a fresh cs fall.

Decomposition:
- Shared package soc_spi_pkg:
  - state encoding (IDLE, CMD, DATA);
  - constants CMD_RW_BIT=7 and SPI_BYTE_BITS=8;
  - default ID_BYTE value.
- Sub-module spi_pin_sync: 2-FF synchronizer plus rise/fall detect, instantiated for sck, mosi and cs (mosi uses only the synced output).

Test Plan:
- Reset released, idle bus -> all outputs 0, busy=0, loc_rdata=8'h00 for every loc_addr.
- Write frame, sck = clk/10: cs low, send 8'h03, 8'h5A, cs high -> wr_pulse once with wr_addr=3 and wr_data=8'h5A; loc_addr=3 gives 8'h5A; MISO bits during the command byte = 8'hA5.
- Read burst with wrap: preload reg15=8'h11 and reg0=8'h22 by SPI write, then send 8'h8F followed by two dummy bytes -> master captures 8'hA5, 8'h11, 8'h22.
- Abort mid-byte: write command 8'h04 then 5 data bits, cs high -> no wr_pulse, reg4 unchanged, busy=0 within 4 clk of cs rise, spi_miso_oe=0.
- Reset mid-frame: assert reset during a read data byte -> spi_miso_oe=0 immediately; all regs read 8'h00; the next full write frame works normally.
- Write burst of 3 bytes 8'hA0, 8'hA1, 8'hA2 starting at addr 14 -> regs 14, 15 and 0 updated in that order, three wr_pulses.
